// File: rtl/sync_fiford_fwft.sv
// FWFT read controller: OUT/SKID output stage fed from a 1-cycle-latency memory.
// Latency 3 cycles from wptr_i change to rvalid_o; reads throttle when OUT and SKID are committed.
module sync_fiford_fwft #(
    parameter int AW       = 3,
    parameter int DW       = 32,
    parameter int AE_LEVEL = 2
) (
    input  logic          rclk,
    input  logic          rst,
    input  logic          rfifo_i,
    input  logic [AW:0]   wptr_i,
    input  logic [DW-1:0] rdata_i,
    output logic          ren_o,
    output logic [AW-1:0] raddr_o,
    output logic [AW:0]   rptr_o,
    output logic [DW-1:0] rdata_o,
    output logic          rvalid_o,
    output logic          rempty_o,
    output logic          raempty_o,
    output logic [AW:0]   rlevel_o,
    output logic          runderr_o
);

    logic [AW:0]   rptr_q, rptr_d;
    logic [1:0]    occ_q, occ_d;
    logic          fetch_q;
    logic [DW-1:0] out_q, out_d;
    logic [DW-1:0] skid_q, skid_d;
    logic          runderr_q;

    logic          pop;
    logic          notempty;
    logic [1:0]    committed;
    logic          load_out;
    logic [AW+1:0] ae_sum;

    assign pop       = rfifo_i & rvalid_o;
    assign notempty  = (rptr_q != wptr_i);
    // Entries already owned by the output stage, including the word still in flight.
    assign committed = occ_q + {1'b0, fetch_q};
    assign ren_o     = notempty & ((committed - {1'b0, pop}) < 2'd2);
    assign rptr_d    = rptr_q + {{AW{1'b0}}, ren_o};
    assign occ_d     = committed - {1'b0, pop};
    assign load_out  = fetch_q & ((occ_q == 2'd0) | (pop & (occ_q == 2'd1)));

    always_comb begin
        out_d  = out_q;
        skid_d = skid_q;
        if (pop && (occ_q == 2'd2)) begin
            out_d = skid_q;
        end else if (load_out) begin
            out_d = rdata_i;
        end
        if (fetch_q && !load_out) begin
            skid_d = rdata_i;
        end
    end

    always_ff @(posedge rclk) begin
        if (rst) begin
            rptr_q    <= '0;
            occ_q     <= '0;
            fetch_q   <= 1'b0;
            out_q     <= '0;
            skid_q    <= '0;
            runderr_q <= 1'b0;
        end else begin
            rptr_q    <= rptr_d;
            occ_q     <= occ_d;
            fetch_q   <= ren_o;
            out_q     <= out_d;
            skid_q    <= skid_d;
            runderr_q <= rfifo_i & ~rvalid_o;
        end
    end

    assign ae_sum = {1'b0, rlevel_o} + (AW+2)'(occ_q) + (AW+2)'(fetch_q);

    assign raddr_o   = rptr_q[AW-1:0];
    assign rptr_o    = rptr_q;
    assign rdata_o   = out_q;
    assign rvalid_o  = (occ_q != 2'd0);
    assign rempty_o  = ~rvalid_o;
    assign rlevel_o  = wptr_i - rptr_q;
    assign raempty_o = (ae_sum <= (AW+2)'(AE_LEVEL));
    assign runderr_o = runderr_q;

endmodule

// File: tb/tb_sync_fiford_fwft.sv
// Bench for sync_fiford_fwft: memory model plus write-side stimulus, scoreboard on pops.
module tb_sync_fiford_fwft;

    localparam int AW = 3;
    localparam int DW = 32;

    logic          rclk = 1'b0;
    logic          rst;
    logic          rfifo_i;
    logic [AW:0]   wptr_i;
    logic [DW-1:0] rdata_i;
    logic          ren_o;
    logic [AW-1:0] raddr_o;
    logic [AW:0]   rptr_o;
    logic [DW-1:0] rdata_o;
    logic          rvalid_o;
    logic          rempty_o;
    logic          raempty_o;
    logic [AW:0]   rlevel_o;
    logic          runderr_o;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] exp_q [$];
    int            n_cmp = 0;
    int            n_err = 0;
    int            ren_cnt = 0;
    int            popped = 0;

    sync_fiford_fwft #(.AW(AW), .DW(DW), .AE_LEVEL(2)) dut (
        .rclk      (rclk),
        .rst       (rst),
        .rfifo_i   (rfifo_i),
        .wptr_i    (wptr_i),
        .rdata_i   (rdata_i),
        .ren_o     (ren_o),
        .raddr_o   (raddr_o),
        .rptr_o    (rptr_o),
        .rdata_o   (rdata_o),
        .rvalid_o  (rvalid_o),
        .rempty_o  (rempty_o),
        .raempty_o (raempty_o),
        .rlevel_o  (rlevel_o),
        .runderr_o (runderr_o)
    );

    always #5 rclk = ~rclk;

    // Synchronous-read memory: data appears the cycle after ren_o.
    always @(posedge rclk) begin
        if (ren_o) rdata_i <= mem[raddr_o];
        if (ren_o) ren_cnt <= ren_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic push(input logic [DW-1:0] w);
        mem[wptr_i[AW-1:0]] = w;
        wptr_i = wptr_i + 1'b1;
        exp_q.push_back(w);
    endtask

    // Called at a negedge with inputs set; scores a pop if one happens at the next edge.
    task automatic tick();
        if (rfifo_i && rvalid_o) begin
            popped++;
            if (exp_q.size() == 0) chk("pop_unexpected", 64'(rdata_o), 64'hdead);
            else chk("pop_data", 64'(rdata_o), 64'(exp_q.pop_front()));
        end
        @(negedge rclk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rfifo_i = 1'b0;
        wptr_i = '0;
        exp_q.delete();
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int ren0;
        int gaps;
        logic seen_wrap;
        logic [AW:0] lvl;

        rst = 1'b1;
        rfifo_i = 1'b0;
        wptr_i = '0;
        rdata_i = '0;
        @(negedge rclk);
        do_reset();
        #1;
        chk("rst_rptr", 64'(rptr_o), 64'd0);
        chk("rst_rvalid", 64'(rvalid_o), 64'd0);
        chk("rst_rempty", 64'(rempty_o), 64'd1);
        chk("rst_rlevel", 64'(rlevel_o), 64'd0);
        chk("rst_raempty", 64'(raempty_o), 64'd1);
        chk("rst_ren", 64'(ren_o), 64'd0);
        chk("rst_runderr", 64'(runderr_o), 64'd0);

        // Single word: read issued at once, visible two edges later.
        push(32'hA000_0000);
        #1;
        chk("lat_ren", 64'(ren_o), 64'd1);
        chk("lat_raddr", 64'(raddr_o), 64'd0);
        tick();
        chk("lat_rvalid_early", 64'(rvalid_o), 64'd0);
        chk("lat_rptr", 64'(rptr_o), 64'd1);
        tick();
        chk("lat_rvalid", 64'(rvalid_o), 64'd1);
        chk("lat_rdata", 64'(rdata_o), 64'hA000_0000);
        rfifo_i = 1'b1;
        tick();
        rfifo_i = 1'b0;
        chk("lat_empty", 64'(rempty_o), 64'd1);

        // Four entries without popping: only OUT and SKID fill.
        ren0 = ren_cnt;
        for (int i = 0; i < 4; i++) push(32'hB000_0000 + 32'(i));
        for (int i = 0; i < 6; i++) tick();
        chk("hold_ren_pulses", 64'(ren_cnt - ren0), 64'd2);
        chk("hold_rlevel", 64'(rlevel_o), 64'd2);
        chk("hold_rdata", 64'(rdata_o), 64'hB000_0000);
        rfifo_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("burst_rvalid", 64'(rvalid_o), 64'd1);
            tick();
        end
        rfifo_i = 1'b0;
        chk("burst_empty", 64'(rempty_o), 64'd1);

        // Streaming 12 words across the pointer wrap.
        do_reset();
        popped = 0;
        gaps = 0;
        seen_wrap = 1'b0;
        rfifo_i = 1'b1;
        for (int c = 0; c < 80 && popped < 12; c++) begin
            lvl = wptr_i - rptr_o;
            if (wptr_i < 4'd12 && lvl < 4'd8 && !(wptr_i == 4'd0 && c > 0))
                push(32'hC000_0000 + 32'(wptr_i));
            if (popped > 0 && !rvalid_o) gaps++;
            if (rptr_o == 4'd8 && !seen_wrap) begin
                seen_wrap = 1'b1;
                chk("wrap_raddr", 64'(raddr_o), 64'd0);
            end
            tick();
        end
        rfifo_i = 1'b0;
        chk("stream_count", 64'(popped), 64'd12);
        chk("stream_gaps", 64'(gaps), 64'd0);
        chk("stream_wrap_seen", 64'(seen_wrap), 64'd1);
        chk("stream_rptr", 64'(rptr_o), 64'd12);
        chk("stream_empty", 64'(rempty_o), 64'd1);

        // Underflow: one-cycle pulse, nothing else moves.
        rfifo_i = 1'b1;
        tick();
        rfifo_i = 1'b0;
        chk("undr_pulse", 64'(runderr_o), 64'd1);
        chk("undr_rptr", 64'(rptr_o), 64'd12);
        chk("undr_rvalid", 64'(rvalid_o), 64'd0);
        tick();
        chk("undr_clear", 64'(runderr_o), 64'd0);
        chk("undr_rptr2", 64'(rptr_o), 64'd12);

        // Almost-empty threshold around 2 entries.
        for (int i = 0; i < 3; i++) push(32'hD000_0000 + 32'(i));
        for (int i = 0; i < 4; i++) tick();
        chk("ae_rlevel", 64'(rlevel_o), 64'd1);
        chk("ae_three", 64'(raempty_o), 64'd0);
        rfifo_i = 1'b1;
        tick();
        rfifo_i = 1'b0;
        chk("ae_two", 64'(raempty_o), 64'd1);
        chk("ae_rvalid", 64'(rvalid_o), 64'd1);
        rfifo_i = 1'b1;
        tick();
        tick();
        rfifo_i = 1'b0;
        chk("ae_drained", 64'(rempty_o), 64'd1);
        chk("ae_queue", 64'(exp_q.size()), 64'd0);

        // Reset with a read in flight: stale memory data must not surface.
        for (int i = 0; i < 3; i++) push(32'hE000_0000 + 32'(i));
        tick();
        do_reset();
        #1;
        chk("mid_rvalid", 64'(rvalid_o), 64'd0);
        chk("mid_ren", 64'(ren_o), 64'd0);
        chk("mid_rptr", 64'(rptr_o), 64'd0);
        chk("mid_rdata", 64'(rdata_o), 64'd0);
        tick();
        tick();
        chk("mid_rvalid_late", 64'(rvalid_o), 64'd0);
        chk("mid_rdata_late", 64'(rdata_o), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sync_fiford_fwft.md
SYNC_FIFORD_FWFT -- requirements
Module: sync_fiford_fwft

Interface
REQ-001 SHALL have parameter AW, default 3, meaning FIFO memory address width (depth 2^AW), matching the write controller's AW.
REQ-002 SHALL have parameter DW, default 32, meaning data width.
REQ-003 SHALL have parameter AE_LEVEL, default 2, meaning almost-empty threshold in total entries.
REQ-004 SHALL have port rclk  input  1  read clock; the one clock, rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port rfifo_i  input  1  consumer pop request.
REQ-007 SHALL have port wptr_i  input  AW+1  write pointer (wrap bit + address) from the write controller.
REQ-008 SHALL have port rdata_i  input  DW  memory read data, valid the cycle after ren_o.
REQ-009 SHALL have port ren_o  output  1  memory read enable.
REQ-010 SHALL have port raddr_o  output  AW  memory read address, equal to rptr_o[AW-1:0].
REQ-011 SHALL have port rptr_o  output  AW+1  read pointer, for the write controller's rptr_i.
REQ-012 SHALL have port rdata_o  output  DW  head-of-queue data (first-word-fall-through).
REQ-013 SHALL have port rvalid_o  output  1  rdata_o holds a valid entry.
REQ-014 SHALL have port rempty_o  output  1  equal to ~rvalid_o.
REQ-015 SHALL have port raempty_o  output  1  almost-empty flag.
REQ-016 SHALL have port rlevel_o  output  AW+1  entries still in memory, wptr_i - rptr_o modulo 2^(AW+1).
REQ-017 SHALL have port runderr_o  output  1  one-cycle underflow pulse.

Function
REQ-018 SHALL keep an output stage of two registers, OUT (head, drives rdata_o) and SKID, an occupancy count occ (0..2), and a flag fetch_q marking a read in flight.
REQ-019 SHALL define pop = rfifo_i & rvalid_o and notempty = (rptr_o != wptr_i).
REQ-020 SHALL drive ren_o = notempty & (occ + fetch_q - pop < 2), combinationally.
REQ-021 SHALL increment rptr_o by 1 at the clock edge of every cycle with ren_o=1, wrapping from 2^(AW+1)-1 to 0.
REQ-022 SHALL set fetch_q to ren_o at every clock edge.
REQ-023 SHALL, in a cycle with fetch_q=1, capture rdata_i at the clock edge into OUT if OUT is empty or being popped with SKID empty, else into SKID.
REQ-024 SHALL, on pop with SKID valid, move SKID to OUT at the edge, combined with REQ-023 so that order is preserved.
REQ-025 SHALL deliver entries strictly in write order: OUT first, then SKID, then the in-flight word.
REQ-026 SHALL keep the invariant occ + fetch_q <= 2, so that occ=2 implies fetch_q=0.
REQ-027 SHALL have a latency of 3 cycles from wptr_i change to rvalid_o when empty: ren_o in cycle W+1, rdata_i in W+2, rvalid_o in W+3.
REQ-028 SHALL sustain one pop per cycle in steady state with occ=1, fetch_q=1.
REQ-029 SHALL assert rvalid_o = (occ != 0), registered.
REQ-030 SHALL hold rdata_o stable while rvalid_o=1 and no pop occurs.
REQ-031 SHALL drive raempty_o = (rlevel_o + occ + fetch_q <= AE_LEVEL), computed at AW+2 bits.
REQ-032 SHALL register runderr_o = rfifo_i & ~rvalid_o, so it is high for exactly the next cycle.
REQ-033 SHALL make underflow change no other state.
REQ-034 SHALL ignore rfifo_i when rvalid_o=0.
REQ-035 SHALL issue no reads when memory is empty (rptr_o == wptr_i), including when the wrap bits are equal.
REQ-036 SHALL, on a pointer wrap (e.g. rptr_o 0111->1000 for AW=3), wrap raddr_o to 0 and toggle rptr_o[AW].

Reset
REQ-037 SHALL, on rst=1 at a clock edge, clear rptr_o, occ, fetch_q, OUT, SKID, rdata_o and runderr_o to 0.
REQ-038 SHALL, after reset, give rvalid_o=0, rempty_o=1, ren_o=0 and raempty_o=1 with wptr_i=0.
REQ-039 SHALL, on reset mid-operation, discard buffered and in-flight data; the write controller shares the reset.
REQ-040 SHALL ignore rdata_i in the cycle after reset even if ren_o was high before it.

Verification
REQ-041 SHALL be verified with reset held 2 cycles -> rptr_o=0, rvalid_o=0, rempty_o=1, rlevel_o=0, raempty_o=1, ren_o=0.
REQ-042 SHALL be verified with AW=3: wptr_i 0->1 at edge W -> ren_o=1, raddr_o=0 in W+1; rvalid_o=1 with rdata_o=word0 in W+3; rptr_o=1.
REQ-043 SHALL be verified with 4 entries and rfifo_i=0 -> exactly 2 ren_o pulses, rlevel_o=2, occ=2, rdata_o=word0; then rfifo_i=1 -> words 0,1,2,3 on consecutive cycles, then rempty_o=1.
REQ-044 SHALL be verified with 12 entries streamed through, rfifo_i held 1 -> data in order with no gaps after the first, rptr_o passes 0111->1000, raddr_o wraps to 0, final rptr_o=1100.
REQ-045 SHALL be verified with rfifo_i=1 while empty -> runderr_o=1 for one cycle, rptr_o/occ unchanged.
REQ-046 SHALL be verified with AE_LEVEL=2 and 3 entries -> raempty_o=0; after one pop -> raempty_o=1.
